// File: rtl/sobel_window_fetcher.sv
// Frame sequencer: fetches each pixel's 3x3 window from a
// single-port BRAM and writes the saturated Sobel magnitude.
module sobel_window_fetcher #(
  parameter int H_RES  = 512,
  parameter int V_RES  = 384,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 18,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [10:0]            x_o,
  output logic [10:0]            y_o,
  input  logic [8:0][ADDR_W-1:0] add_i,
  output logic [ADDR_W-1:0]      mem_addr_o,
  input  logic [PIX_W-1:0]       mem_data_i,
  output logic                   out_we,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [PIX_W-1:0]       out_data,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CALC, WRITE, DONE
  } state_t;

  localparam logic [10:0] XMAX = 11'(H_RES - 1);
  localparam logic [10:0] YMAX = 11'(V_RES - 1);
  localparam logic [2:0]  WMAX = 3'(RD_LAT - 1);
  localparam logic [11:0] PMAX = 12'((1 << PIX_W) - 1);

  state_t state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [3:0] idx_q, idx_d;
  logic [2:0] cnt_q, cnt_d;

  logic [RD_LAT-1:0] vld_q, msk_q;
  logic [3:0] tag_q [RD_LAT];
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] data_q;

  logic row0, row2, col0, col2, msk;
  logic signed [11:0] gx, gy, ax, ay;
  logic [11:0] mag;
  logic [PIX_W-1:0] sat;

  function automatic logic signed [11:0] sx(
    input logic [PIX_W-1:0] v
  );
    return signed'(12'(v));
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ISSUE;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
        end
      end
      ISSUE: begin
        if (idx_q == 4'd8) begin
          state_d = WAIT;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      WAIT: begin
        if (cnt_q == WMAX) state_d = CALC;
        else cnt_d = cnt_q + 3'd1;
      end
      CALC: state_d = WRITE;
      WRITE: begin
        state_d = ISSUE;
        if (x_q == XMAX && y_q == YMAX) begin
          state_d = DONE;
          x_d     = '0;
          y_d     = '0;
        end else if (x_q < XMAX) begin
          x_d = x_q + 11'd1;
        end else begin
          x_d = '0;
          y_d = y_q + 11'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Out-of-frame neighbours are zeroed at capture, not by address.
  always_comb begin
    row0 = idx_q < 4'd3;
    row2 = idx_q > 4'd5;
    col0 = idx_q == 4'd0 || idx_q == 4'd3 || idx_q == 4'd6;
    col2 = idx_q == 4'd2 || idx_q == 4'd5 || idx_q == 4'd8;
    msk  = (row0 && y_q == '0) || (row2 && y_q == YMAX) ||
           (col0 && x_q == '0) || (col2 && x_q == XMAX);
  end

  always_comb begin
    mem_addr_o = '0;
    if (state_q == ISSUE) mem_addr_o = add_i[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      msk_q  <= '0;
      data_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      vld_q[0] <= state_q == ISSUE;
      msk_q[0] <= msk;
      tag_q[0] <= idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        msk_q[i] <= msk_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
      if (vld_q[RD_LAT-1])
        win_q[tag_q[RD_LAT-1]] <=
          msk_q[RD_LAT-1] ? '0 : mem_data_i;
      if (state_q == CALC) data_q <= sat;
    end
  end

  always_comb begin
    gx = (sx(win_q[2]) + sx(win_q[5]) + sx(win_q[5]) + sx(win_q[8]))
       - (sx(win_q[0]) + sx(win_q[3]) + sx(win_q[3]) + sx(win_q[6]));
    gy = (sx(win_q[6]) + sx(win_q[7]) + sx(win_q[7]) + sx(win_q[8]))
       - (sx(win_q[0]) + sx(win_q[1]) + sx(win_q[1]) + sx(win_q[2]));
    ax  = gx[11] ? -gx : gx;
    ay  = gy[11] ? -gy : gy;
    mag = $unsigned(ax) + $unsigned(ay);
    sat = (mag > PMAX) ? '1 : mag[PIX_W-1:0];
  end

  assign x_o      = x_q;
  assign y_o      = y_q;
  assign out_we   = state_q == WRITE;
  assign out_addr = ADDR_W'(int'(x_q) + int'(y_q) * H_RES);
  assign out_data = data_q;
  assign busy     = state_q inside {ISSUE, WAIT, CALC, WRITE};
  assign done     = state_q == DONE;

endmodule
